// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with 2-bit saturating direction counters for the fetch stage.
// Latency: lookup is combinational in the same cycle; training takes effect at the next rising edge.
// Backpressure: none; a lookup happens every cycle and every training or flush strobe is accepted.
module branch_predictor_btb #(
    parameter int NUM_ENTRIES = 16,
    localparam int IDX_BITS = $clog2(NUM_ENTRIES),
    localparam int TAG_BITS = 30 - IDX_BITS
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic [31:0] fetch_pc,
    output logic        predicted_outcome,
    output logic [31:0] predicted_pc,
    output logic        btb_hit,
    input  logic        update_btb,
    input  logic [31:0] update_pc,
    input  logic        branch_outcome,
    input  logic [31:0] branch_target,
    input  logic        flush_btb
);

    // Table storage. Only valid and ctr are reset; tag and target are
    // meaningless while the entry is invalid.
    logic [NUM_ENTRIES-1:0] valid_q;
    logic [TAG_BITS-1:0]    tag_q    [NUM_ENTRIES];
    logic [31:0]            target_q [NUM_ENTRIES];
    logic [1:0]             ctr_q    [NUM_ENTRIES];

    logic [IDX_BITS-1:0] fetch_idx;
    logic [TAG_BITS-1:0] fetch_tag;
    logic [IDX_BITS-1:0] upd_idx;
    logic [TAG_BITS-1:0] upd_tag;
    logic                upd_hit;
    logic                upd_taken_wr;

    // Word-aligned PCs: the two byte-offset bits never take part in indexing.
    logic unused_pc_lsbs;
    assign unused_pc_lsbs = ^{fetch_pc[1:0], update_pc[1:0]};

    assign fetch_idx = fetch_pc[IDX_BITS+1:2];
    assign fetch_tag = fetch_pc[31:IDX_BITS+2];
    assign upd_idx   = update_pc[IDX_BITS+1:2];
    assign upd_tag   = update_pc[31:IDX_BITS+2];

    // Same-cycle lookup on pre-update state; no bypass of a concurrent write.
    always_comb begin
        btb_hit           = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
        predicted_outcome = btb_hit && ctr_q[fetch_idx][1];
        predicted_pc      = predicted_outcome ? target_q[fetch_idx] : (fetch_pc + 32'd4);
    end

    // Resolve whether the branch being trained already owns its entry.
    always_comb begin
        upd_hit      = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
        upd_taken_wr = update_btb && !flush_btb && branch_outcome;
    end

    // Valid bits and direction counters; flush wins over a same-cycle update.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ctr_q[i] <= 2'b01;
            end
        end else if (flush_btb) begin
            valid_q <= '0;
        end else if (update_btb) begin
            if (upd_hit) begin
                if (branch_outcome) begin
                    if (ctr_q[upd_idx] != 2'b11) begin
                        ctr_q[upd_idx] <= ctr_q[upd_idx] + 2'd1;
                    end
                end else if (ctr_q[upd_idx] != 2'b00) begin
                    ctr_q[upd_idx] <= ctr_q[upd_idx] - 2'd1;
                end
            end else if (branch_outcome) begin
                // Taken miss allocates (or evicts an alias) as weakly taken.
                valid_q[upd_idx] <= 1'b1;
                ctr_q[upd_idx]   <= 2'b10;
            end
        end
    end

    // Tag and target: every taken resolution refreshes the target, a miss also claims the tag.
    always_ff @(posedge CLK) begin
        if (nRST && upd_taken_wr) begin
            target_q[upd_idx] <= branch_target;
            if (!upd_hit) begin
                tag_q[upd_idx] <= upd_tag;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: vector table plus hand-written reset sequence.
// Latency: expectations are checked half a cycle after each vector is driven.
// Backpressure: none; the bench drives one vector per cycle.
module tb_branch_predictor_btb;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic [31:0] fetch_pc = 32'h0;
    logic        predicted_outcome;
    logic [31:0] predicted_pc;
    logic        btb_hit;
    logic        update_btb = 1'b0;
    logic [31:0] update_pc = 32'h0;
    logic        branch_outcome = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        flush_btb = 1'b0;

    branch_predictor_btb #(.NUM_ENTRIES(16)) dut (
        .CLK               (CLK),
        .nRST              (nRST),
        .fetch_pc          (fetch_pc),
        .predicted_outcome (predicted_outcome),
        .predicted_pc      (predicted_pc),
        .btb_hit           (btb_hit),
        .update_btb        (update_btb),
        .update_pc         (update_pc),
        .branch_outcome    (branch_outcome),
        .branch_target     (branch_target),
        .flush_btb         (flush_btb)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        upd;
        logic [31:0] upc;
        logic        out;
        logic [31:0] tgt;
        logic        flush;
        logic [31:0] fpc;
        logic        e_hit;
        logic        e_out;
        logic [31:0] e_pc;
    } vec_t;

    typedef struct {
        int          id;
        logic        e_hit;
        logic        e_out;
        logic [31:0] e_pc;
    } exp_t;

    vec_t vecs[$];
    exp_t exp_q[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(input logic upd, input logic [31:0] upc, input logic out,
                                input logic [31:0] tgt, input logic flush, input logic [31:0] fpc,
                                input logic eh, input logic eo, input logic [31:0] ep);
        vec_t v;
        v.upd = upd; v.upc = upc; v.out = out; v.tgt = tgt; v.flush = flush;
        v.fpc = fpc; v.e_hit = eh; v.e_out = eo; v.e_pc = ep;
        return v;
    endfunction

    task automatic check(input int id, input logic eh, input logic eo, input logic [31:0] ep);
        n_total++;
        if (btb_hit !== eh || predicted_outcome !== eo || predicted_pc !== ep)
            $display("FAIL lookup%0d: got hit=%b out=%b pc=%h, expected hit=%b out=%b pc=%h",
                     id, btb_hit, predicted_outcome, predicted_pc, eh, eo, ep);
        else
            n_pass++;
    endtask

    // Drive one vector just after the rising edge and queue its expected lookup.
    task automatic apply(input vec_t v, input int id);
        exp_t e;
        @(posedge CLK);
        #1;
        update_btb     = v.upd;
        update_pc      = v.upc;
        branch_outcome = v.out;
        branch_target  = v.tgt;
        flush_btb      = v.flush;
        fetch_pc       = v.fpc;
        e.id = id; e.e_hit = v.e_hit; e.e_out = v.e_out; e.e_pc = v.e_pc;
        exp_q.push_back(e);
    endtask

    task automatic drain();
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            n_total++;
            $display("FAIL drain: %0d expectations outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    // Scoreboard: compare the oldest queued expectation on each falling edge.
    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check(e.id, e.e_hit, e.e_out, e.e_pc);
        end
    end

    initial begin
        // Reset state, checked while reset is still held.
        repeat (2) @(posedge CLK);
        #1;
        fetch_pc = 32'h100;
        #1;
        check(90, 1'b0, 1'b0, 32'h104);
        @(negedge CLK);
        nRST = 1'b1;

        //           upd   upc           out   tgt           fl    fetch         hit   out   pc
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100,      1'b0, 1'b0, 32'h104));
        vecs.push_back(mk(1'b1, 32'h100,      1'b1, 32'h80,       1'b0, 32'h100,      1'b0, 1'b0, 32'h104));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100,      1'b1, 1'b1, 32'h80));
        vecs.push_back(mk(1'b1, 32'h100,      1'b0, 32'hBAD0,     1'b0, 32'h100,      1'b1, 1'b1, 32'h80));
        vecs.push_back(mk(1'b1, 32'h100,      1'b0, 32'hBAD0,     1'b0, 32'h100,      1'b1, 1'b0, 32'h104));
        vecs.push_back(mk(1'b1, 32'h100,      1'b0, 32'hBAD0,     1'b0, 32'h100,      1'b1, 1'b0, 32'h104));
        vecs.push_back(mk(1'b1, 32'h100,      1'b1, 32'h90,       1'b0, 32'h100,      1'b1, 1'b0, 32'h104));
        vecs.push_back(mk(1'b1, 32'h100,      1'b1, 32'h94,       1'b0, 32'h100,      1'b1, 1'b0, 32'h104));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100,      1'b1, 1'b1, 32'h94));
        vecs.push_back(mk(1'b1, 32'h100,      1'b1, 32'h94,       1'b0, 32'h100,      1'b1, 1'b1, 32'h94));
        vecs.push_back(mk(1'b1, 32'h100,      1'b1, 32'h94,       1'b0, 32'h100,      1'b1, 1'b1, 32'h94));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100,      1'b1, 1'b1, 32'h94));
        vecs.push_back(mk(1'b1, 32'h100,      1'b0, 32'hBAD0,     1'b0, 32'h100,      1'b1, 1'b1, 32'h94));
        vecs.push_back(mk(1'b1, 32'h100,      1'b0, 32'hBAD0,     1'b0, 32'h100,      1'b1, 1'b1, 32'h94));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100,      1'b1, 1'b0, 32'h104));
        vecs.push_back(mk(1'b1, 32'h100,      1'b1, 32'h80,       1'b0, 32'h100,      1'b1, 1'b0, 32'h104));
        // Aliasing on index 0.
        vecs.push_back(mk(1'b1, 32'h140,      1'b1, 32'h200,      1'b0, 32'h140,      1'b0, 1'b0, 32'h144));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h140,      1'b1, 1'b1, 32'h200));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100,      1'b0, 1'b0, 32'h104));
        vecs.push_back(mk(1'b1, 32'h180,      1'b0, 32'h999,      1'b0, 32'h180,      1'b0, 1'b0, 32'h184));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h140,      1'b1, 1'b1, 32'h200));
        // Unknown data while the strobe is low must not disturb the table.
        vecs.push_back(mk(1'b0, 32'hx,        1'bx, 32'hx,        1'b0, 32'h140,      1'b1, 1'b1, 32'h200));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h140,      1'b1, 1'b1, 32'h200));
        // Another index, address wrap, ignored low bits.
        vecs.push_back(mk(1'b1, 32'h104,      1'b1, 32'h300,      1'b0, 32'h104,      1'b0, 1'b0, 32'h108));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h104,      1'b1, 1'b1, 32'h300));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'hFFFFFFFC, 1'b0, 1'b0, 32'h0));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h142,      1'b1, 1'b1, 32'h200));
        // Flush with a simultaneous update: lookup sees pre-flush state, update dropped.
        vecs.push_back(mk(1'b1, 32'h100,      1'b1, 32'h80,       1'b1, 32'h140,      1'b1, 1'b1, 32'h200));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100,      1'b0, 1'b0, 32'h104));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h140,      1'b0, 1'b0, 32'h144));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h104,      1'b0, 1'b0, 32'h108));
        vecs.push_back(mk(1'b1, 32'h100,      1'b1, 32'h80,       1'b0, 32'h100,      1'b0, 1'b0, 32'h104));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100,      1'b1, 1'b1, 32'h80));
        // Not-taken miss never allocates.
        vecs.push_back(mk(1'b1, 32'h200,      1'b0, 32'h999,      1'b0, 32'h200,      1'b0, 1'b0, 32'h204));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h200,      1'b0, 1'b0, 32'h204));
        vecs.push_back(mk(1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h100,      1'b1, 1'b1, 32'h80));

        foreach (vecs[i]) apply(vecs[i], i);
        drain();

        // Populate indices 0..7, then confirm one of them hits.
        for (int i = 0; i < 8; i++)
            apply(mk(1'b1, 32'h1000 + 4 * i, 1'b1, 32'h2000 + 4 * i, 1'b0, 32'h1000 + 4 * i,
                     1'b0, 1'b0, 32'h1004 + 4 * i), 200 + i);
        apply(mk(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h101C, 1'b1, 1'b1, 32'h201C), 208);
        drain();

        // Asynchronous reset in the middle of a training cycle.
        @(posedge CLK);
        #1;
        update_btb     = 1'b1;
        update_pc      = 32'h1010;
        branch_outcome = 1'b1;
        branch_target  = 32'h4000;
        flush_btb      = 1'b0;
        fetch_pc       = 32'h1010;
        #1;
        check(209, 1'b1, 1'b1, 32'h2010);
        #1;
        nRST = 1'b0;
        #1;
        check(210, 1'b0, 1'b0, 32'h1014);
        for (int i = 0; i < 8; i++) begin
            fetch_pc = 32'h1000 + 4 * i;
            #1;
            check(211 + i, 1'b0, 1'b0, 32'h1004 + 4 * i);
        end
        repeat (2) @(posedge CLK);
        #1;
        fetch_pc = 32'h1010;
        #1;
        check(220, 1'b0, 1'b0, 32'h1014);
        @(negedge CLK);
        nRST       = 1'b1;
        update_btb = 1'b0;
        #1;
        check(221, 1'b0, 1'b0, 32'h1014);

        // After release a taken update allocates weakly taken: one not-taken drops it to 01.
        apply(mk(1'b1, 32'h1008, 1'b1, 32'h3000, 1'b0, 32'h1008, 1'b0, 1'b0, 32'h100C), 230);
        apply(mk(1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h1008, 1'b1, 1'b1, 32'h3000), 231);
        apply(mk(1'b1, 32'h1008, 1'b0, 32'h0,    1'b0, 32'h1008, 1'b1, 1'b1, 32'h3000), 232);
        apply(mk(1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h1008, 1'b1, 1'b0, 32'h100C), 233);
        apply(mk(1'b0, 32'h0,    1'b0, 32'h0,    1'b0, 32'h1000, 1'b0, 1'b0, 32'h1004), 234);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
